// File: rtl/shift_reg_univ.sv
// shift_reg_univ
//   Universal WIDTH-bit register: hold, parallel load, logical/arithmetic
//   shifts, rotates and bitwise set/reset, gated by a clock enable.
//
// Parameters
//   WIDTH        register width in bits (>= 2)
//   RESET_VALUE  value loaded by synchronous reset
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset (priority over ena/mode)
//   ena       clock enable; 0 holds q
//   mode      operation select
//             000 hold, 001 load, 010 shl, 011 lsr,
//             100 rol,  101 ror,  110 asr, 111 set/reset
//   d         parallel load data (mode 001)
//   s, r      per-bit set / reset masks (mode 111, r wins)
//   sin_lsb   serial input into bit 0 on shift left
//   sin_msb   serial input into bit WIDTH-1 on logical shift right
//   q         register contents
//   sout_msb  q[WIDTH-1]
//   sout_lsb  q[0]
//   zero      q == 0
module shift_reg_univ #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_SR   = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] q_next;

  assign op = op_e'(mode);

  always_comb begin
    q_next = q;
    case (op)
      OP_HOLD: q_next = q;
      OP_LOAD: q_next = d;
      OP_SHL:  q_next = {q[WIDTH-2:0], sin_lsb};
      OP_LSR:  q_next = {sin_msb, q[WIDTH-1:1]};
      OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      // Reset mask applied last so r dominates where both masks are set.
      OP_SR:   q_next = (q | s) & ~r;
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (ena) begin
      q <= q_next;
    end
  end

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];
  assign zero     = (q == '0);

endmodule
